// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared types and constants for the alarm scheduler block.
//   state_e       : scheduler FSM states (IDLE / SCAN / RING)
//   *_W           : bit widths of the hours / minutes / seconds fields
//   MAX_*         : largest legal value of each time field
//   slot_t        : one alarm slot {en, h, m, s}
//   snoozeTarget  : adds a minute offset to a time of day, wrapping at 24h
// ---------------------------------------------------------------------------
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RING = 2'd2
   } state_e;

   localparam int HOURS_W = 5;
   localparam int MINS_W  = 6;
   localparam int SECS_W  = 6;

   localparam int MAX_SECS  = 59;
   localparam int MAX_MINS  = 59;
   localparam int MAX_HOURS = 23;

   typedef struct packed {
      logic               en;
      logic [HOURS_W-1:0] h;
      logic [MINS_W-1:0]  m;
      logic [SECS_W-1:0]  s;
   } slot_t;

   // Builds an armed slot that lies addMins minutes after the given time.
   // Seconds are carried over untouched; minute overflow bumps the hour and
   // hour 24 folds back to midnight. addMins is at most 59, so a single
   // subtraction of 60 is always enough.
   function automatic slot_t snoozeTarget(input logic [HOURS_W-1:0] baseH,
                                          input logic [MINS_W-1:0]  baseM,
                                          input logic [SECS_W-1:0]  baseS,
                                          input logic [MINS_W-1:0]  addMins);
      logic [MINS_W:0]    minSum;
      logic [HOURS_W-1:0] hourNext;
      minSum   = {1'b0, baseM} + {1'b0, addMins};
      hourNext = baseH;
      if (minSum > 7'(MAX_MINS)) begin
         minSum   = minSum - 7'd60;
         hourNext = baseH + 5'd1;
      end
      if (hourNext > 5'(MAX_HOURS)) begin
         hourNext = '0;
      end
      snoozeTarget.en = 1'b1;
      snoozeTarget.h  = hourNext;
      snoozeTarget.m  = minSum[MINS_W-1:0];
      snoozeTarget.s  = baseS;
   endfunction

endpackage

// File: rtl/alarm_slot_bank.sv
// ---------------------------------------------------------------------------
// alarm_slot_bank
// Register file holding the programmable alarm slots.
//   clk, reset   : system clock, synchronous active-high reset (clears slots)
//   wr_en_i      : write strobe
//   wr_idx_i     : slot to write; indices >= NUM_ALARMS are dropped
//   wr_slot_i    : slot contents {en, h, m, s}
//   rd_idx_i     : slot to read (combinational)
//   rd_slot_o    : slot contents; all-zero (disabled) for out-of-range index
// ---------------------------------------------------------------------------
module alarm_slot_bank
   import alarm_pkg::*;
#(
   parameter int NUM_ALARMS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en_i,
   input  logic [2:0] wr_idx_i,
   input  slot_t      wr_slot_i,
   input  logic [2:0] rd_idx_i,
   output slot_t      rd_slot_o
);

   slot_t slots_q [NUM_ALARMS];

   // Slot storage. Each slot only responds to its own index, so a write to an
   // index beyond the implemented slots simply finds no taker and is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            slots_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (wr_en_i && (wr_idx_i == 3'(i))) begin
               slots_q[i] <= wr_slot_i;
            end
         end
      end
   end

   // Read mux. The scanner reads one slot per clock and sees any write that
   // has already landed, which is how mid-scan writes to not-yet-scanned
   // slots get picked up.
   always_comb begin
      rd_slot_o = '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (rd_idx_i == 3'(i)) begin
            rd_slot_o = slots_q[i];
         end
      end
   end

endmodule

// File: rtl/alarm_scheduler.sv
// ---------------------------------------------------------------------------
// alarm_scheduler
// Decides when the buzzer sounds, given NUM_ALARMS programmable alarm slots
// plus (optionally) one snooze slot, driven by the 24h timekeeper's time.
//   clk, reset             : system clock, synchronous active-high reset
//   tick_1hz               : one-clk pulse per second
//   cur_hours/mins/secs    : current time of day
//   cfg_we, cfg_idx        : slot write strobe and slot index
//   cfg_en, cfg_hours/mins/secs : slot contents to write
//   dismiss                : stop ringing, drop any pending snooze
//   snooze                 : stop ringing, re-ring SNOOZE_MINS later
//   buzzer, ringing        : high while ringing
//   active_idx             : slot of the current/last ring (NUM_ALARMS = snooze)
// Build option: define ALARM_SNOOZE_EN to include the snooze slot and the
// snooze input; without it the snooze input is ignored and the scan covers
// only the programmable slots.
// ---------------------------------------------------------------------------
module alarm_scheduler
   import alarm_pkg::*;
#(
   parameter int NUM_ALARMS  = 4,
   parameter int RING_SECS   = 30,
   parameter int SNOOZE_MINS = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick_1hz,
   input  logic [HOURS_W-1:0] cur_hours,
   input  logic [MINS_W-1:0]  cur_mins,
   input  logic [SECS_W-1:0]  cur_secs,
   input  logic               cfg_we,
   input  logic [2:0]         cfg_idx,
   input  logic               cfg_en,
   input  logic [HOURS_W-1:0] cfg_hours,
   input  logic [MINS_W-1:0]  cfg_mins,
   input  logic [SECS_W-1:0]  cfg_secs,
   input  logic               dismiss,
   input  logic               snooze,
   output logic               buzzer,
   output logic               ringing,
   output logic [2:0]         active_idx
);

`ifdef ALARM_SNOOZE_EN
   localparam logic [3:0] SNOOZE_IDX = 4'(NUM_ALARMS);
   localparam logic [3:0] LAST_IDX   = 4'(NUM_ALARMS);
`else
   localparam logic [3:0] LAST_IDX   = 4'(NUM_ALARMS - 1);
`endif
   localparam logic [5:0] RING_INIT  = 6'(RING_SECS);

   state_e             state_q, state_d;
   logic [3:0]         scanIdx_q, scanIdx_d;
   logic [5:0]         ringCnt_q, ringCnt_d;
   logic [2:0]         activeIdx_q, activeIdx_d;
   logic [HOURS_W-1:0] snapHours_q;
   logic [MINS_W-1:0]  snapMins_q;
   logic [SECS_W-1:0]  snapSecs_q;
   logic               snapLoad;
   slot_t              cfgSlot;
   slot_t              bankSlot;
   slot_t              curSlot;
   logic               slotMatch;

   assign cfgSlot = '{en: cfg_en, h: cfg_hours, m: cfg_mins, s: cfg_secs};

   alarm_slot_bank #(
      .NUM_ALARMS (NUM_ALARMS)
   ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (cfg_we),
      .wr_idx_i  (cfg_idx),
      .wr_slot_i (cfgSlot),
      .rd_idx_i  (scanIdx_q[2:0]),
      .rd_slot_o (bankSlot)
   );

`ifdef ALARM_SNOOZE_EN
   slot_t snoozeSlot_q, snoozeSlot_d;
   slot_t snoozeArm;

   // Where the snooze slot would point if snooze were pressed now. The
   // snapshot still holds the time of the scan that started this ring.
   assign snoozeArm = snoozeTarget(snapHours_q, snapMins_q, snapSecs_q, 6'(SNOOZE_MINS));

   // The snooze slot lives here rather than in the bank because it is
   // written by the FSM, not by the configuration port. Its en bit is the
   // "armed" flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         snoozeSlot_q <= '0;
      end else begin
         snoozeSlot_q <= snoozeSlot_d;
      end
   end

   // The scan's final step looks at the snooze slot instead of the bank.
   assign curSlot = (scanIdx_q == SNOOZE_IDX) ? snoozeSlot_q : bankSlot;
`else
   logic unusedSnooze;
   assign unusedSnooze = snooze;
   assign curSlot      = bankSlot;
`endif

   // A slot fires on an exact h/m/s match with the latched snapshot. Hours
   // above 23 can be programmed but are explicitly kept from ever matching.
   assign slotMatch = curSlot.en
                   && (curSlot.h <= 5'(MAX_HOURS))
                   && (curSlot.h == snapHours_q)
                   && (curSlot.m == snapMins_q)
                   && (curSlot.s == snapSecs_q);

   assign snapLoad = (state_q == IDLE) && tick_1hz;

   // State, scan pointer, ring counter and the time snapshot. The snapshot is
   // only taken when a scan starts, so it stays frozen through SCAN and RING
   // and later serves as the base for the snooze time.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         scanIdx_q   <= '0;
         ringCnt_q   <= '0;
         activeIdx_q <= '0;
         snapHours_q <= '0;
         snapMins_q  <= '0;
         snapSecs_q  <= '0;
      end else begin
         state_q     <= state_d;
         scanIdx_q   <= scanIdx_d;
         ringCnt_q   <= ringCnt_d;
         activeIdx_q <= activeIdx_d;
         if (snapLoad) begin
            snapHours_q <= cur_hours;
            snapMins_q  <= cur_mins;
            snapSecs_q  <= cur_secs;
         end
      end
   end

   // Next-state logic. The scan walks the slots in priority order and stops
   // at the first match, so later matches in the same second are never seen.
   // While ringing no scan runs; ticks only count down the ring time. A tick
   // arriving mid-scan is dropped because only IDLE reacts to it.
   always_comb begin
      state_d      = state_q;
      scanIdx_d    = scanIdx_q;
      ringCnt_d    = ringCnt_q;
      activeIdx_d  = activeIdx_q;
`ifdef ALARM_SNOOZE_EN
      snoozeSlot_d = snoozeSlot_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (tick_1hz) begin
               state_d   = SCAN;
               scanIdx_d = '0;
            end
         end
         SCAN: begin
            if (slotMatch) begin
               state_d     = RING;
               activeIdx_d = scanIdx_q[2:0];
               ringCnt_d   = RING_INIT;
`ifdef ALARM_SNOOZE_EN
               if (scanIdx_q == SNOOZE_IDX) begin
                  snoozeSlot_d.en = 1'b0;
               end
`endif
            end else if (scanIdx_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               scanIdx_d = scanIdx_q + 4'd1;
            end
         end
         RING: begin
            if (dismiss) begin
               state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
               snoozeSlot_d.en = 1'b0;
`endif
            end
`ifdef ALARM_SNOOZE_EN
            else if (snooze) begin
               state_d      = IDLE;
               snoozeSlot_d = snoozeArm;
            end
`endif
            else if (tick_1hz) begin
               if (ringCnt_q <= 6'd1) begin
                  state_d   = IDLE;
                  ringCnt_d = '0;
               end else begin
                  ringCnt_d = ringCnt_q - 6'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The buzzer is driven straight from the state, so a reset sampled during
   // a ring silences it on the following clock.
   assign ringing    = (state_q == RING);
   assign buzzer     = (state_q == RING);
   assign active_idx = activeIdx_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alarm_scheduler
// Exercises alarm_scheduler second by second against a time-of-day model
// that works in seconds since midnight. Honours ALARM_SNOOZE_EN the same way
// the design does.
// ---------------------------------------------------------------------------
module tb_alarm_scheduler;

   localparam int NUM_ALARMS  = 4;
   localparam int RING_SECS   = 30;
   localparam int SNOOZE_MINS = 5;
   localparam int DAY_SECS    = 86400;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNOOZE_ON = 1'b1;
`else
   localparam bit SNOOZE_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_1hz = 1'b0;
   logic [4:0] cur_hours = '0;
   logic [5:0] cur_mins = '0;
   logic [5:0] cur_secs = '0;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_idx = '0;
   logic       cfg_en = 1'b0;
   logic [4:0] cfg_hours = '0;
   logic [5:0] cfg_mins = '0;
   logic [5:0] cfg_secs = '0;
   logic       dismiss = 1'b0;
   logic       snooze = 1'b0;
   logic       buzzer;
   logic       ringing;
   logic [2:0] active_idx;

   int checkCount = 0;
   int errorCount = 0;

   int slotEn [8];
   int slotH  [8];
   int slotT  [8];
   bit mRinging;
   int mRemain;
   int mIdx;
   int mRingTime;
   bit mSnzArmed;
   int mSnzT;

   alarm_scheduler #(
      .NUM_ALARMS  (NUM_ALARMS),
      .RING_SECS   (RING_SECS),
      .SNOOZE_MINS (SNOOZE_MINS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tick_1hz   (tick_1hz),
      .cur_hours  (cur_hours),
      .cur_mins   (cur_mins),
      .cur_secs   (cur_secs),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_en     (cfg_en),
      .cfg_hours  (cfg_hours),
      .cfg_mins   (cfg_mins),
      .cfg_secs   (cfg_secs),
      .dismiss    (dismiss),
      .snooze     (snooze),
      .buzzer     (buzzer),
      .ringing    (ringing),
      .active_idx (active_idx)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   function automatic int hms(input int h, input int m, input int s);
      return h * 3600 + m * 60 + s;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Model reset: every slot off, nothing ringing, no snooze pending.
   task automatic modelReset();
      for (int i = 0; i < 8; i++) begin
         slotEn[i] = 0;
         slotH[i]  = 0;
         slotT[i]  = 0;
      end
      mRinging  = 1'b0;
      mRemain   = 0;
      mIdx      = 0;
      mRingTime = 0;
      mSnzArmed = 1'b0;
      mSnzT     = 0;
   endtask

   // Button handling in the model: dismiss beats snooze, both only matter
   // while ringing, and snooze counts from the second the ring began.
   task automatic modelControl(input bit dis, input bit snz);
      if (mRinging) begin
         if (dis) begin
            mRinging  = 1'b0;
            mSnzArmed = 1'b0;
         end else if (snz && SNOOZE_ON) begin
            mRinging  = 1'b0;
            mSnzArmed = 1'b1;
            mSnzT     = (mRingTime + SNOOZE_MINS * 60) % DAY_SECS;
         end
      end
   endtask

   // One second of model time: a ringing alarm just counts down; otherwise
   // the lowest enabled slot whose time equals now wins, then the snooze slot.
   task automatic modelTick(input int now);
      int win;
      if (mRinging) begin
         mRemain--;
         if (mRemain == 0) begin
            mRinging = 1'b0;
         end
      end else begin
         win = -1;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (win < 0 && slotEn[i] != 0 && slotH[i] <= 23 && slotT[i] == now) begin
               win = i;
            end
         end
         if (win < 0 && SNOOZE_ON && mSnzArmed && mSnzT == now) begin
            win       = NUM_ALARMS;
            mSnzArmed = 1'b0;
         end
         if (win >= 0) begin
            mRinging  = 1'b1;
            mRemain   = RING_SECS;
            mIdx      = win;
            mRingTime = now;
         end
      end
   endtask

   task automatic applyReset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      modelReset();
   endtask

   // One configuration write; the model drops out-of-range indices.
   task automatic writeSlot(input int idx, input int en, input int hh, input int mm, input int ss);
      cfg_we    = 1'b1;
      cfg_idx   = 3'(idx);
      cfg_en    = (en != 0);
      cfg_hours = 5'(hh);
      cfg_mins  = 6'(mm);
      cfg_secs  = 6'(ss);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      if (idx < NUM_ALARMS) begin
         slotEn[idx] = en;
         slotH[idx]  = hh;
         slotT[idx]  = hms(hh, mm, ss);
      end
   endtask

   // One simulated second: optional button pulse, then the 1 Hz tick, then
   // the outputs are compared once the scan has had time to finish. A fresh
   // ring must appear exactly (winning index + 1) clocks after the tick.
   task automatic applyStimulus(input int now, input bit dis, input bit snz);
      bit wasRinging;
      bit newRing;
      int firstRing;
      cur_hours = 5'(now / 3600);
      cur_mins  = 6'((now / 60) % 60);
      cur_secs  = 6'(now % 60);
      dismiss   = dis;
      snooze    = snz;
      @(posedge clk);
      #1;
      dismiss = 1'b0;
      snooze  = 1'b0;
      modelControl(dis, snz);
      wasRinging = mRinging;
      modelTick(now);
      newRing  = !wasRinging && mRinging;
      tick_1hz = 1'b1;
      @(posedge clk);
      #1;
      tick_1hz  = 1'b0;
      firstRing = -1;
      for (int c = 1; c <= NUM_ALARMS + 3; c++) begin
         @(posedge clk);
         #1;
         if (firstRing < 0 && ringing) begin
            firstRing = c;
         end
      end
      if (newRing) begin
         checkOutput("ringLatency", firstRing, mIdx + 1);
      end
      checkOutput("ringing", int'(ringing), int'(mRinging));
      checkOutput("buzzer", int'(buzzer), int'(mRinging));
      checkOutput("activeIdx", int'(active_idx), mIdx);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Directed scenarios first, then randomized rounds around a moving base
   // time, occasionally steered onto a pending snooze time or midnight.
   initial begin
      int base;
      int t;
      int idx;
      int hh;
      bit dis;
      bit snz;

      modelReset();
      applyReset();
      checkOutput("resetRinging", int'(ringing), 0);
      checkOutput("resetBuzzer", int'(buzzer), 0);
      checkOutput("resetActiveIdx", int'(active_idx), 0);

      $display("[TB] single slot match");
      writeSlot(1, 1, 7, 0, 5);
      applyStimulus(hms(7, 0, 4), 1'b0, 1'b0);
      applyStimulus(hms(7, 0, 5), 1'b0, 1'b0);
      applyStimulus(hms(7, 0, 6), 1'b1, 1'b0);

      $display("[TB] priority between equal slots");
      writeSlot(0, 1, 12, 0, 0);
      writeSlot(2, 1, 12, 0, 0);
      applyStimulus(hms(12, 0, 0), 1'b0, 1'b0);
      applyStimulus(hms(12, 0, 1), 1'b1, 1'b0);
      applyStimulus(hms(12, 0, 2), 1'b0, 1'b0);

      $display("[TB] auto timeout and disabled slot");
      writeSlot(3, 1, 6, 30, 0);
      applyStimulus(hms(6, 30, 0), 1'b0, 1'b0);
      for (int s = 1; s <= RING_SECS + 1; s++) begin
         applyStimulus(hms(6, 30, 0) + s, 1'b0, 1'b0);
      end
      writeSlot(3, 0, 6, 40, 0);
      applyStimulus(hms(6, 40, 0), 1'b0, 1'b0);

      $display("[TB] snooze across midnight");
      writeSlot(2, 1, 23, 58, 10);
      applyStimulus(hms(23, 58, 10), 1'b0, 1'b0);
      applyStimulus(hms(23, 58, 11), 1'b0, 1'b1);
      applyStimulus(hms(0, 3, 9), 1'b0, 1'b0);
      applyStimulus(hms(0, 3, 10), 1'b0, 1'b0);
      applyStimulus(hms(0, 3, 11), 1'b1, 1'b0);
      applyStimulus(hms(23, 58, 10), 1'b0, 1'b0);
      applyStimulus(hms(23, 58, 11), 1'b1, 1'b1);
      applyStimulus(hms(0, 3, 10), 1'b0, 1'b0);

      $display("[TB] reset during ring");
      writeSlot(0, 1, 9, 0, 0);
      applyStimulus(hms(9, 0, 0), 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midRingResetBuzzer", int'(buzzer), 0);
      checkOutput("midRingResetRinging", int'(ringing), 0);
      reset = 1'b0;
      modelReset();
      applyStimulus(hms(9, 0, 0), 1'b0, 1'b0);
      applyStimulus(hms(7, 0, 5), 1'b0, 1'b0);

      $display("[TB] dropped write and out-of-range hours");
      writeSlot(7, 1, 10, 0, 0);
      checkOutput("droppedWriteRinging", int'(ringing), 0);
      checkOutput("droppedWriteActiveIdx", int'(active_idx), 0);
      writeSlot(1, 1, 25, 0, 0);
      applyStimulus(hms(10, 0, 0), 1'b0, 1'b0);
      applyStimulus(hms(1, 0, 0), 1'b0, 1'b0);

      $display("[TB] randomized rounds");
      for (int r = 0; r < 14; r++) begin
         if (SNOOZE_ON && mSnzArmed && $urandom_range(0, 1) == 1) begin
            base = (mSnzT + DAY_SECS - 3) % DAY_SECS;
         end else if ($urandom_range(0, 3) == 0) begin
            base = DAY_SECS - 5;
         end else begin
            base = $urandom_range(0, DAY_SECS - 1);
         end
         for (int w = 0; w < 4; w++) begin
            t   = (base + $urandom_range(0, 10)) % DAY_SECS;
            idx = $urandom_range(0, 7);
            hh  = t / 3600;
            if ($urandom_range(0, 7) == 0) begin
               hh = $urandom_range(24, 31);
            end
            writeSlot(idx, ($urandom_range(0, 3) != 0) ? 1 : 0, hh, (t / 60) % 60, t % 60);
         end
         for (int s = 0; s < 12; s++) begin
            dis = 1'b0;
            snz = 1'b0;
            if (mRinging) begin
               dis = ($urandom_range(0, 3) == 0);
               snz = ($urandom_range(0, 3) == 0);
            end
            applyStimulus((base + s) % DAY_SECS, dis, snz);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
